// File: rtl/rsa_pkg.sv
// Shared constants and types for the RSA operand fetch path.
package rsa_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned NWORDS     = 64;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned BASE_B     = 0;
    localparam int unsigned BASE_E     = 64;
    localparam int unsigned BASE_N     = 128;
    localparam int unsigned FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        SEL_B = 2'd0,
        SEL_E = 2'd1,
        SEL_N = 2'd2
    } sel_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // Region order is B -> E -> N; N is terminal.
    function automatic sel_e next_sel(input sel_e sel);
        return (sel == SEL_B) ? SEL_E : SEL_N;
    endfunction

endpackage

// File: rtl/rsa_operand_fetch_if.sv
// SRAM read port and tagged operand stream between the fetcher and its neighbours.
interface rsa_operand_fetch_if #(
    parameter int unsigned WORD_W = rsa_pkg::WORD_W,
    parameter int unsigned ADDR_W = rsa_pkg::ADDR_W
);

    logic              sram_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [WORD_W-1:0] sram_data;

    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [1:0]        out_sel;
    logic [rsa_pkg::IDX_W-1:0] out_idx;
    logic              out_last;

    modport master (
        output sram_en,
        output sram_addr,
        input  sram_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_sel,
        output out_idx,
        output out_last
    );

    modport slave (
        input  sram_en,
        input  sram_addr,
        output sram_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_sel,
        input  out_idx,
        input  out_last
    );

endinterface

// File: rtl/rsa_fetch_fifo.sv
// Small synchronous FIFO holding tagged operand words between SRAM capture and the consumer.
module rsa_fetch_fifo #(
    parameter int unsigned WIDTH = 41,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rsa_operand_fetch.sv
// Walks the B, E and N regions of the operand SRAM and streams each word, tagged
// with region and index, to the modexp core over valid/ready.
module rsa_operand_fetch #(
    parameter int unsigned WORD_W     = rsa_pkg::WORD_W,
    parameter int unsigned ADDR_W     = rsa_pkg::ADDR_W,
    parameter int unsigned NWORDS     = rsa_pkg::NWORDS,
    parameter int unsigned BASE_B     = rsa_pkg::BASE_B,
    parameter int unsigned BASE_E     = rsa_pkg::BASE_E,
    parameter int unsigned BASE_N     = rsa_pkg::BASE_N,
    parameter int unsigned FIFO_DEPTH = rsa_pkg::FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    rsa_operand_fetch_if.master bus
);

    import rsa_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SEL_W = $bits(sel_e);
    localparam int unsigned FW    = WORD_W + SEL_W + IDX_W + 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);
    localparam logic [CNT_W:0]   ROOM     = (CNT_W + 1)'(FIFO_DEPTH);

    state_e            state;
    state_e            state_nx;

    logic [ADDR_W-1:0] addr_q;
    sel_e              sel_q;
    logic [IDX_W-1:0]  idx_q;

    logic              inflight;
    sel_e              inf_sel;
    logic [IDX_W-1:0]  inf_idx;

    logic              issue;
    logic              last_issue;
    logic              pop;
    logic [CNT_W:0]    occupancy;

    logic [FW-1:0]     fifo_din;
    logic [FW-1:0]     fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [SEL_W-1:0]  head_sel;

    // Slots already claimed after this cycle's handshake; a read is only issued
    // when its word is guaranteed a FIFO entry two edges later.
    assign pop        = !fifo_empty && bus.out_ready;
    assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight}
                        - {{CNT_W{1'b0}}, pop};
    assign issue      = (state == RUN) && (occupancy < ROOM);
    assign last_issue = issue && (sel_q == SEL_N) && (idx_q == IDX_LAST);

    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign bus.sram_en   = issue;
    assign bus.sram_addr = addr_q;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_issue) state_nx = DRAIN;
            DRAIN:   if (occupancy == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            sel_q  <= SEL_B;
            idx_q  <= '0;
        end else if (state == IDLE && start) begin
            addr_q <= ADDR_W'(BASE_B);
            sel_q  <= SEL_B;
            idx_q  <= '0;
        end else if (issue) begin
            if (idx_q == IDX_LAST) begin
                idx_q  <= '0;
                sel_q  <= next_sel(sel_q);
                addr_q <= (sel_q == SEL_B) ? ADDR_W'(BASE_E)
                        : (sel_q == SEL_E) ? ADDR_W'(BASE_N)
                        : addr_q + ADDR_W'(1);
            end else begin
                idx_q  <= idx_q + IDX_W'(1);
                addr_q <= addr_q + ADDR_W'(1);
            end
        end
    end

    // The tag follows the read for the one cycle the SRAM needs to return data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            inf_sel  <= SEL_B;
            inf_idx  <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inf_sel <= sel_q;
                inf_idx <= idx_q;
            end
        end
    end

    assign fifo_din = {bus.sram_data, inf_sel, inf_idx, (inf_idx == IDX_LAST)};

    rsa_fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.out_valid = !fifo_empty;
    assign {bus.out_data, head_sel, bus.out_idx, bus.out_last} = fifo_dout;
    assign bus.out_sel   = head_sel;

    no_overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(inflight && fifo_full && !pop));

endmodule

// File: tb/tb_rsa_operand_fetch.sv
// Randomized self-checking bench: SRAM model with ram[i] = A5000000|i, expected
// word stream derived from region arithmetic.
module tb_rsa_operand_fetch;

    import rsa_pkg::*;

    localparam int TOTAL = 3 * NWORDS;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    int n_checks = 0;
    int n_errors = 0;

    logic [WORD_W-1:0] ram [2**ADDR_W];

    rsa_operand_fetch_if bus ();

    rsa_operand_fetch #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.sram_en) bus.sram_data <= ram[bus.sram_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_addr(input int k);
        int region = k / NWORDS;
        int base = (region == 0) ? int'(BASE_B) : (region == 1) ? int'(BASE_E) : int'(BASE_N);
        return base + (k % NWORDS);
    endfunction

    function automatic logic [40:0] exp_word(input int k);
        int idx = k % NWORDS;
        logic [31:0] data = 32'hA500_0000 | 32'(exp_addr(k));
        return {data, 2'(k / NWORDS), 6'(idx), (idx == NWORDS - 1)};
    endfunction

    function automatic logic [63:0] outs_vec();
        return 64'({busy, done, bus.sram_en, bus.sram_addr, bus.out_valid,
                    bus.out_data, bus.out_sel, bus.out_idx, bus.out_last});
    endfunction

    // mode 0: ready held high; 1: random ready plus stray start pulses;
    // 2: ready low for 20 cycles from the first valid. abort_word >= 0 resets mid-pass.
    task automatic run_pass(input int mode, input int abort_word);
        int n_out = 0;
        int n_iss = 0;
        int first_valid = -1;
        int last_hs = -1;
        int done_cyc = -1;
        logic held_valid = 1'b0;
        logic [40:0] held = '0;
        logic [40:0] cur;
        logic rdy;
        logic hs;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start = (cyc == 0) || (mode == 1 && cyc == 60);
            case (mode)
                1:       rdy = 1'($urandom_range(0, 1));
                2:       rdy = (first_valid >= 0) && (cyc >= first_valid + 20);
                default: rdy = 1'b1;
            endcase
            bus.out_ready = rdy;
            #1;

            if (abort_word >= 0 && n_out == abort_word) begin
                rst = 1'b1;
                #1;
                check("reset_mid_run", outs_vec(), 64'd0);
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                return;
            end

            cur = {bus.out_data, bus.out_sel, bus.out_idx, bus.out_last};
            if (held_valid) begin
                check("stall_valid_held", 64'(bus.out_valid), 64'd1);
                check("stall_fields_held", 64'(cur), 64'(held));
            end

            if (mode == 0 && cyc == 0) check("busy_before_start", 64'(busy), 64'd0);
            if (mode == 0 && cyc == 1)
                check("first_issue", 64'({busy, bus.sram_en, bus.sram_addr}),
                      64'({1'b1, 1'b1, 8'(BASE_B)}));

            if (bus.out_valid && first_valid < 0) first_valid = cyc;

            hs = bus.out_valid && rdy;
            if (bus.sram_en) begin
                check("issue_room", 64'((n_iss - n_out - int'(hs)) < int'(FIFO_DEPTH)), 64'd1);
                check("issue_addr", 64'(bus.sram_addr), 64'(exp_addr(n_iss)));
                n_iss++;
            end

            if (mode == 2 && first_valid >= 0 && !rdy) begin
                check("stall_no_issue", 64'(bus.sram_en), 64'd0);
                if (cyc == first_valid + 19)
                    check("stall_buffered", 64'(n_iss - n_out), 64'(FIFO_DEPTH));
            end

            if (hs) begin
                if (n_out < TOTAL) check("word", 64'(cur), 64'(exp_word(n_out)));
                else               check("extra_word", 64'(n_out), 64'(TOTAL - 1));
                n_out++;
                last_hs = cyc;
                held_valid = 1'b0;
            end else begin
                held_valid = bus.out_valid;
                held = cur;
            end

            if (done) begin
                done_cyc = cyc;
                check("done_busy", 64'(busy), 64'd1);
                check("done_words", 64'(n_out), 64'(TOTAL));
                break;
            end
        end

        check("done_seen", 64'(done_cyc >= 0), 64'd1);
        check("issue_total", 64'(n_iss), 64'(TOTAL));
        if (mode == 0) begin
            check("first_valid_cycle", 64'(first_valid), 64'd3);
            check("last_handshake_cycle", 64'(last_hs), 64'd194);
            check("done_cycle", 64'(done_cyc), 64'd195);
        end

        // A start landing in the DONE cycle must not launch another pass.
        start = (mode == 1);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("after_done", 64'({busy, done}), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("idle_quiet", 64'({busy, bus.sram_en, bus.out_valid}), 64'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) ram[i] = 32'hA500_0000 | 32'(i);
        rst = 1'b1;
        start = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", outs_vec(), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_pass(0, -1);
        run_pass(1, -1);
        run_pass(2, -1);
        run_pass(1, -1);
        run_pass(0, 100);
        run_pass(0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
